// File: rtl/axil_mport_sram_pkg.sv
// Shared types for the multi-port AXI-lite scratch SRAM.
// Response codes, per-port transaction states and width helpers.
package axil_mport_sram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        IDLE,
        WRESP,
        RRESP
    } port_state_e;

    // Width of the word index left after dropping the byte-lane bits.
    function automatic int idx_width(input int aw, input int dw);
        return aw - $clog2(dw / 8);
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_mport_sram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector.
// The search starts at the pointer, which moves past each winner.
module rr_arbiter #(
    parameter int N = 8,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx,
    output logic          gvld
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nx;
    int            idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        gvld  = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!gvld && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
                gvld       = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_nx = ptr;
        if (gvld) begin
            ptr_nx = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nx;
        end
    end

endmodule

// File: rtl/axil_mport_sram.sv
// NPORT AXI-lite slave ports sharing one single-ported word memory.
// One access per cycle, chosen round-robin; one outstanding op per port.
module axil_mport_sram
    import axil_mport_sram_pkg::*;
#(
    parameter int NPORT = 8,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic [NPORT-1:0]      AXI_AWVALID,
    output logic [NPORT-1:0]      AXI_AWREADY,
    input  logic [NPORT*AW-1:0]   AXI_AWADDR,
    input  logic [NPORT-1:0]      AXI_WVALID,
    output logic [NPORT-1:0]      AXI_WREADY,
    input  logic [NPORT*DW-1:0]   AXI_WDATA,
    input  logic [NPORT*DW/8-1:0] AXI_WSTRB,
    output logic [NPORT-1:0]      AXI_BVALID,
    input  logic [NPORT-1:0]      AXI_BREADY,
    output logic [2*NPORT-1:0]    AXI_BRESP,
    input  logic [NPORT-1:0]      AXI_ARVALID,
    output logic [NPORT-1:0]      AXI_ARREADY,
    input  logic [NPORT*AW-1:0]   AXI_ARADDR,
    output logic [NPORT-1:0]      AXI_RVALID,
    input  logic [NPORT-1:0]      AXI_RREADY,
    output logic [NPORT*DW-1:0]   AXI_RDATA,
    output logic [2*NPORT-1:0]    AXI_RRESP
);

    localparam int BW  = DW / 8;
    localparam int OFF = $clog2(BW);
    localparam int IW  = idx_width(AW, DW);
    localparam int MW  = clog2_min1(DEPTH);
    localparam int PW  = clog2_min1(NPORT);

    port_state_e st    [NPORT];
    port_state_e st_nx [NPORT];

    logic [NPORT-1:0] last_wr;
    logic [NPORT-1:0] req_wr;
    logic [NPORT-1:0] req_rd;
    logic [NPORT-1:0] want_wr;
    logic [NPORT-1:0] req;
    logic [NPORT-1:0] grant;
    logic [PW-1:0]    gidx;
    logic             gvld;

    logic          wr_go;
    logic          rd_go;
    logic [AW-1:0] sel_addr;
    logic [IW-1:0] word;
    logic          in_range;
    logic [MW-1:0] maddr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wstrb;

    logic [DW-1:0]       mem [DEPTH];
    logic [DW-1:0]       mem_q;
    logic                fresh;
    logic [PW-1:0]       rd_port;
    logic                rd_oor;
    logic [DW-1:0]       fresh_data;
    logic [NPORT*DW-1:0] rdata_hold;
    logic [2*NPORT-1:0]  bresp_q;
    logic [2*NPORT-1:0]  rresp_q;

    // A port asking for both ops alternates, starting with a read.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            req_wr[p]  = (st[p] == IDLE) && AXI_AWVALID[p] && AXI_WVALID[p];
            req_rd[p]  = (st[p] == IDLE) && AXI_ARVALID[p];
            want_wr[p] = req_wr[p] && (!req_rd[p] || !last_wr[p]);
            req[p]     = req_wr[p] || req_rd[p];
        end
    end

    rr_arbiter #(.N(NPORT)) u_arb (
        .CLK   (CLK),
        .RST_X (RST_X),
        .req   (req),
        .grant (grant),
        .gidx  (gidx),
        .gvld  (gvld)
    );

    assign AXI_AWREADY = grant & want_wr;
    assign AXI_WREADY  = grant & want_wr;
    assign AXI_ARREADY = grant & ~want_wr;

    always_comb begin
        wr_go    = gvld && want_wr[gidx];
        rd_go    = gvld && !want_wr[gidx];
        sel_addr = wr_go ? AXI_AWADDR[int'(gidx)*AW +: AW]
                         : AXI_ARADDR[int'(gidx)*AW +: AW];
        word     = IW'(sel_addr >> OFF);
        in_range = word < IW'(DEPTH);
        maddr    = word[MW-1:0];
        wdata    = AXI_WDATA[int'(gidx)*DW +: DW];
        wstrb    = AXI_WSTRB[int'(gidx)*BW +: BW];
    end

    always_ff @(posedge CLK) begin
        if (wr_go && in_range) begin
            for (int b = 0; b < BW; b++) begin
                if (wstrb[b]) begin
                    mem[maddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (rd_go && in_range) begin
            mem_q <= mem[maddr];
        end
    end

    // mem_q is only good for the cycle after the read; then it is parked.
    assign fresh_data = rd_oor ? '0 : mem_q;

    always_comb begin
        AXI_RDATA = rdata_hold;
        if (fresh) begin
            AXI_RDATA[int'(rd_port)*DW +: DW] = fresh_data;
        end
    end

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            st_nx[p] = st[p];
            unique case (st[p])
                IDLE: begin
                    if (grant[p]) begin
                        st_nx[p] = want_wr[p] ? WRESP : RRESP;
                    end
                end
                WRESP: begin
                    if (AXI_BREADY[p]) begin
                        st_nx[p] = IDLE;
                    end
                end
                RRESP: begin
                    if (AXI_RREADY[p]) begin
                        st_nx[p] = IDLE;
                    end
                end
                default: st_nx[p] = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int p = 0; p < NPORT; p++) begin
                st[p] <= IDLE;
            end
            last_wr    <= '1;
            bresp_q    <= '0;
            rresp_q    <= '0;
            fresh      <= 1'b0;
            rd_port    <= '0;
            rd_oor     <= 1'b0;
            rdata_hold <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                st[p] <= st_nx[p];
            end
            if (gvld) begin
                last_wr[gidx] <= want_wr[gidx];
            end
            if (wr_go) begin
                bresp_q[int'(gidx)*2 +: 2] <= in_range ? OKAY : SLVERR;
            end
            if (rd_go) begin
                rresp_q[int'(gidx)*2 +: 2] <= in_range ? OKAY : SLVERR;
                rd_port <= gidx;
                rd_oor  <= !in_range;
            end
            fresh <= rd_go;
            if (fresh) begin
                rdata_hold[int'(rd_port)*DW +: DW] <= fresh_data;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            AXI_BVALID[p] = (st[p] == WRESP);
            AXI_RVALID[p] = (st[p] == RRESP);
        end
    end

    assign AXI_BRESP = bresp_q;
    assign AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_axil_mport_sram.sv
// Bench for axil_mport_sram: directed steps plus randomized traffic
// checked against a word-array memory and round-robin reference model.
module tb_axil_mport_sram;

    localparam int NP    = 8;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic             CLK = 1'b0;
    logic             RST_X;
    logic [NP-1:0]    AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
    logic [NP*AW-1:0] AXI_AWADDR, AXI_ARADDR;
    logic [NP*DW-1:0] AXI_WDATA, AXI_RDATA;
    logic [NP*4-1:0]  AXI_WSTRB;
    logic [NP-1:0]    AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY;
    logic [NP-1:0]    AXI_RVALID, AXI_RREADY;
    logic [2*NP-1:0]  AXI_BRESP, AXI_RRESP;

    axil_mport_sram #(.NPORT(NP), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_AWADDR(AXI_AWADDR),
        .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
        .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_BRESP(AXI_BRESP),
        .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_ARADDR(AXI_ARADDR),
        .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mdl [DEPTH];
    int          ptr_m;
    bit          last_wr_m [NP];
    int          npass = 0;
    int          ntot  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [NP-1:0] r);
        for (int i = 0; i < NP; i++) begin
            if (r[(ptr_m + i) % NP]) return (ptr_m + i) % NP;
        end
        return -1;
    endfunction

    function automatic bit inr(input logic [31:0] a);
        return (a >> 2) < DEPTH;
    endfunction

    function automatic logic [1:0] eresp(input logic [31:0] a);
        return inr(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] edata(input logic [31:0] a);
        return inr(a) ? mdl[a >> 2] : 32'h0;
    endfunction

    function automatic void mwrite(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        if (inr(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl[a >> 2][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] raddr();
        if ($urandom_range(0, 9) == 0) return $urandom();
        return (32'($urandom_range(0, DEPTH + 7)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic wr1(input int p, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        AXI_AWADDR[p*AW +: AW] = a;
        AXI_WDATA[p*DW +: DW]  = d;
        AXI_WSTRB[p*4 +: 4]    = s;
        AXI_AWVALID[p] = 1'b1;
        AXI_WVALID[p]  = 1'b1;
        #1;
        chk("wr_awready", AXI_AWREADY, oh(p));
        chk("wr_wready", AXI_WREADY, oh(p));
        tick();
        AXI_AWVALID[p] = 1'b0;
        AXI_WVALID[p]  = 1'b0;
        mwrite(a, d, s);
        ptr_m        = (p + 1) % NP;
        last_wr_m[p] = 1'b1;
        chk("wr_bvalid", AXI_BVALID, oh(p));
        chk("wr_bresp", AXI_BRESP[p*2 +: 2], eresp(a));
        AXI_BREADY[p] = 1'b1;
        tick();
        AXI_BREADY[p] = 1'b0;
        chk("wr_bvalid_clr", AXI_BVALID[p], 0);
    endtask

    task automatic rd1(input int p, input logic [31:0] a, output logic [31:0] got);
        AXI_ARADDR[p*AW +: AW] = a;
        AXI_ARVALID[p] = 1'b1;
        #1;
        chk("rd_arready", AXI_ARREADY, oh(p));
        tick();
        AXI_ARVALID[p] = 1'b0;
        ptr_m        = (p + 1) % NP;
        last_wr_m[p] = 1'b0;
        got = AXI_RDATA[p*DW +: DW];
        chk("rd_rvalid", AXI_RVALID, oh(p));
        chk("rd_rdata", got, edata(a));
        chk("rd_rresp", AXI_RRESP[p*2 +: 2], eresp(a));
        AXI_RREADY[p] = 1'b1;
        tick();
        AXI_RREADY[p] = 1'b0;
        chk("rd_rvalid_clr", AXI_RVALID[p], 0);
    endtask

    // Several ports request at once; exactly one is served.
    task automatic multi(input logic [NP-1:0] wm, input logic [NP-1:0] rm);
        logic [31:0]   wa [NP];
        logic [31:0]   wd [NP];
        logic [3:0]    ws [NP];
        logic [31:0]   ra [NP];
        logic [NP-1:0] g1;
        int            g;
        bit            w;
        for (int p = 0; p < NP; p++) begin
            wa[p] = raddr();
            wd[p] = $urandom();
            ws[p] = 4'($urandom());
            ra[p] = raddr();
            AXI_AWADDR[p*AW +: AW] = wa[p];
            AXI_WDATA[p*DW +: DW]  = wd[p];
            AXI_WSTRB[p*4 +: 4]    = ws[p];
            AXI_ARADDR[p*AW +: AW] = ra[p];
        end
        AXI_AWVALID = wm;
        AXI_WVALID  = wm;
        AXI_ARVALID = rm;
        #1;
        g  = pick(wm | rm);
        w  = wm[g] && (!rm[g] || !last_wr_m[g]);
        g1 = oh(g);
        chk("mp_awready", AXI_AWREADY, w ? g1 : '0);
        chk("mp_wready", AXI_WREADY, w ? g1 : '0);
        chk("mp_arready", AXI_ARREADY, w ? '0 : g1);
        tick();
        AXI_AWVALID = '0;
        AXI_WVALID  = '0;
        AXI_ARVALID = '0;
        ptr_m        = (g + 1) % NP;
        last_wr_m[g] = w;
        if (w) mwrite(wa[g], wd[g], ws[g]);
        chk("mp_bvalid", AXI_BVALID, w ? g1 : '0);
        chk("mp_rvalid", AXI_RVALID, w ? '0 : g1);
        if (w) chk("mp_bresp", AXI_BRESP[g*2 +: 2], eresp(wa[g]));
        else begin
            chk("mp_rdata", AXI_RDATA[g*DW +: DW], edata(ra[g]));
            chk("mp_rresp", AXI_RRESP[g*2 +: 2], eresp(ra[g]));
        end
        AXI_BREADY = '1;
        AXI_RREADY = '1;
        tick();
        AXI_BREADY = '0;
        AXI_RREADY = '0;
        chk("mp_idle", {AXI_BVALID, AXI_RVALID}, 0);
    endtask

    initial begin
        logic [31:0]   got;
        logic [31:0]   d;
        logic [NP-1:0] seen;
        logic [NP-1:0] wm;
        logic [NP-1:0] rm;
        int            g;

        RST_X = 1'b1;
        AXI_AWVALID = '0; AXI_WVALID = '0; AXI_ARVALID = '0;
        AXI_BREADY  = '0; AXI_RREADY = '0;
        AXI_AWADDR  = '0; AXI_ARADDR = '0; AXI_WDATA = '0; AXI_WSTRB = '0;
        ptr_m = 0;
        for (int p = 0; p < NP; p++) last_wr_m[p] = 1'b1;
        #3 RST_X = 1'b0;
        tick();
        tick();
        chk("rst_ready", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 0);
        chk("rst_valid", {AXI_BVALID, AXI_RVALID}, 0);
        chk("rst_resp", {AXI_BRESP, AXI_RRESP}, 0);
        chk("rst_rdata", AXI_RDATA, 0);
        RST_X = 1'b1;
        tick();

        for (int w = 0; w < DEPTH; w++) wr1(w % NP, 32'(w * 4), $urandom(), 4'hF);

        wr1(0, 32'h10, 32'hDEADBEEF, 4'hF);
        rd1(0, 32'h10, got);
        chk("basic_rdata", got, 32'hDEADBEEF);

        wr1(0, 32'h20, 32'h11223344, 4'hF);
        wr1(0, 32'h20, 32'hAABBCCDD, 4'b0101);
        rd1(0, 32'h20, got);
        chk("strb_merge", got, 32'h11BB33DD);

        // All ports read together from pointer 0.
        rd1(7, 32'h0, got);
        for (int p = 0; p < NP; p++) AXI_ARADDR[p*AW +: AW] = 32'(p * 4);
        AXI_ARVALID = '1;
        seen = '0;
        for (int k = 0; k < NP; k++) begin
            #1;
            g = pick(AXI_ARVALID);
            chk("rr_arready", AXI_ARREADY, oh(g));
            chk("rr_order", g, k);
            tick();
            AXI_ARVALID[g] = 1'b0;
            ptr_m        = (g + 1) % NP;
            last_wr_m[g] = 1'b0;
            seen[g]      = 1'b1;
            chk("rr_rvalid", AXI_RVALID, seen);
            chk("rr_rdata", AXI_RDATA[g*DW +: DW], mdl[g]);
        end
        AXI_RREADY = '1;
        tick();
        AXI_RREADY = '0;
        chk("rr_rvalid_clr", AXI_RVALID, 0);
        multi('0, 8'h11);

        wr1(0, 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF);
        rd1(0, 32'(DEPTH * 4), got);
        chk("oor_rdata", got, 0);
        rd1(0, 32'h0, got);

        // Port 2 stalls its write response while port 3 reads.
        AXI_AWADDR[2*AW +: AW] = 32'h40;
        AXI_WDATA[2*DW +: DW]  = 32'h5A5A1234;
        AXI_WSTRB[2*4 +: 4]    = 4'hF;
        AXI_AWVALID[2] = 1'b1;
        AXI_WVALID[2]  = 1'b1;
        #1;
        chk("bp_awready", AXI_AWREADY, oh(2));
        tick();
        mwrite(32'h40, 32'h5A5A1234, 4'hF);
        ptr_m = 3;
        last_wr_m[2] = 1'b1;
        AXI_ARADDR[3*AW +: AW] = 32'h40;
        AXI_ARVALID[3] = 1'b1;
        #1;
        chk("bp_arready3", AXI_ARREADY, oh(3));
        chk("bp_awready2", AXI_AWREADY[2], 0);
        tick();
        AXI_ARVALID[3] = 1'b0;
        ptr_m = 4;
        last_wr_m[3] = 1'b0;
        chk("bp_rvalid3", AXI_RVALID[3], 1);
        chk("bp_rdata3", AXI_RDATA[3*DW +: DW], mdl[16]);
        AXI_RREADY[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_bvalid2", AXI_BVALID[2], 1);
            chk("bp_hold2", AXI_AWREADY[2], 0);
            chk("bp_bresp2", AXI_BRESP[5:4], 0);
            tick();
            AXI_RREADY[3] = 1'b0;
        end
        chk("bp_rvalid3_clr", AXI_RVALID[3], 0);
        AXI_AWVALID[2] = 1'b0;
        AXI_WVALID[2]  = 1'b0;
        AXI_BREADY[2]  = 1'b1;
        tick();
        AXI_BREADY[2] = 1'b0;
        chk("bp_bvalid2_clr", AXI_BVALID[2], 0);

        // Port 1 with both ops valid after a write: read goes first.
        wr1(1, 32'h80, 32'h01020304, 4'hF);
        d = $urandom();
        AXI_AWADDR[1*AW +: AW] = 32'h80;
        AXI_WDATA[1*DW +: DW]  = d;
        AXI_WSTRB[1*4 +: 4]    = 4'hF;
        AXI_ARADDR[1*AW +: AW] = 32'h80;
        AXI_AWVALID[1] = 1'b1;
        AXI_WVALID[1]  = 1'b1;
        AXI_ARVALID[1] = 1'b1;
        #1;
        chk("both_arready", AXI_ARREADY, oh(1));
        chk("both_awready", AXI_AWREADY, 0);
        tick();
        AXI_ARVALID[1] = 1'b0;
        chk("both_rdata", AXI_RDATA[1*DW +: DW], 32'h01020304);
        AXI_RREADY[1] = 1'b1;
        tick();
        AXI_RREADY[1] = 1'b0;
        chk("both_awready2", AXI_AWREADY, oh(1));
        tick();
        AXI_AWVALID[1] = 1'b0;
        AXI_WVALID[1]  = 1'b0;
        mwrite(32'h80, d, 4'hF);
        chk("both_bvalid", AXI_BVALID, oh(1));
        AXI_BREADY[1] = 1'b1;
        tick();
        AXI_BREADY[1] = 1'b0;
        ptr_m = 2;

        // Reset while a read response is pending.
        AXI_ARVALID[1] = 1'b1;
        tick();
        AXI_ARVALID[1] = 1'b0;
        chk("mid_rvalid", AXI_RVALID[1], 1);
        chk("mid_rdata", AXI_RDATA[1*DW +: DW], d);
        RST_X = 1'b0;
        #1;
        chk("mid_rst_rvalid", AXI_RVALID, 0);
        chk("mid_rst_rdata", AXI_RDATA, 0);
        tick();
        RST_X = 1'b1;
        ptr_m = 0;
        for (int p = 0; p < NP; p++) last_wr_m[p] = 1'b1;
        tick();
        multi('0, 8'b0000_1010);
        rd1(1, 32'h80, got);
        chk("post_rst_data", got, d);

        for (int n = 0; n < 200; n++) begin
            wm = NP'($urandom());
            rm = NP'($urandom());
            if ((wm | rm) == '0) rm = oh($urandom_range(0, NP - 1));
            multi(wm, rm);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
